ascon_perm_arbiter: RTL

ASCON_PERM_ARBITER -- requirements
Module: ascon_perm_arbiter

---
 rtl/ascon_perm_arbiter.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ascon_perm_arbiter.sv
// Shares one masked ASCON permutation core between the encryption and decryption FSMs.
// Round-robin grant, fresh-randomness handshake, watchdog-guarded run, one-cycle response.
module ascon_perm_arbiter #(
    parameter int W      = 320,
    parameter int WD_MAX = 31
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req0,
    input  logic           req1,
    input  logic [4:0]     rounds0,
    input  logic [4:0]     rounds1,
    input  logic [3*W-1:0] sh0,
    input  logic [3*W-1:0] sh1,
    output logic           done0,
    output logic           done1,
    output logic           err0,
    output logic           err1,
    output logic [3*W-1:0] res,
    output logic           busy,
    input  logic           rnd_valid,
    output logic           rnd_ack,
    output logic           p_start,
    output logic [4:0]     p_rounds,
    output logic [3*W-1:0] p_in,
    input  logic [3*W-1:0] p_out,
    input  logic           p_done
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_RND = 2'd1,
        RUN      = 2'd2,
        RESP     = 2'd3
    } state_t;

    localparam logic [4:0] WD_LAST    = 5'(WD_MAX - 1);
    localparam logic [4:0] WD_SAT     = 5'h1f;
    localparam logic [4:0] MAX_ROUNDS = 5'd12;

    state_t         state_r;
    state_t         state_next_s;
    logic           owner_r;
    logic           last_grant_r;
    logic [4:0]     wd_r;
    logic [4:0]     rounds_r;
    logic [3*W-1:0] shares_r;
    logic [3*W-1:0] res_r;
    logic           done0_r;
    logic           done1_r;
    logic           err0_r;
    logic           err1_r;
    logic           busy_r;
    logic           p_start_r;
    logic           grant_s;
    logic           win_s;
    logic           ok_s;
    logic           fail_s;
    logic           rounds_ok_s;

    function automatic logic rounds_legal(input logic [4:0] r);
        return (r != 5'd0) && (r <= MAX_ROUNDS);
    endfunction

    assign rounds_ok_s = rounds_legal(rounds_r);

    // Next-state decision, arbitration winner and job outcome.
    always_comb begin
        state_next_s = state_r;
        grant_s      = 1'b0;
        win_s        = 1'b0;
        ok_s         = 1'b0;
        fail_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (req0 || req1) begin
                    grant_s = 1'b1;
                    if (req0 && req1) begin
                        win_s = ~last_grant_r;
                    end else begin
                        win_s = req1;
                    end
                    state_next_s = WAIT_RND;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WAIT_RND: begin
                // An illegal round count is rejected before any randomness is consumed.
                if (!rounds_ok_s) begin
                    fail_s       = 1'b1;
                    state_next_s = RESP;
                end else if (rnd_valid) begin
                    state_next_s = RUN;
                end else begin
                    state_next_s = WAIT_RND;
                end
            end
            RUN: begin
                if (p_done) begin
                    ok_s         = 1'b1;
                    state_next_s = RESP;
                end else if (wd_r >= WD_LAST) begin
                    fail_s       = 1'b1;
                    state_next_s = RESP;
                end else begin
                    state_next_s = RUN;
                end
            end
            RESP: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // State, latched job, watchdog and registered strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r      <= IDLE;
            owner_r      <= 1'b0;
            last_grant_r <= 1'b1;
            wd_r         <= 5'd0;
            rounds_r     <= 5'd0;
            shares_r     <= {(3*W){1'b0}};
            res_r        <= {(3*W){1'b0}};
            done0_r      <= 1'b0;
            done1_r      <= 1'b0;
            err0_r       <= 1'b0;
            err1_r       <= 1'b0;
            busy_r       <= 1'b0;
            p_start_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (grant_s) begin
                owner_r      <= win_s;
                last_grant_r <= win_s;
                rounds_r     <= win_s ? rounds1 : rounds0;
                shares_r     <= win_s ? sh1 : sh0;
            end
            if (ok_s) begin
                res_r <= p_out;
            end
            // Counts RUN cycles from zero; saturates instead of wrapping.
            if (state_r != RUN) begin
                wd_r <= 5'd0;
            end else if (wd_r != WD_SAT) begin
                wd_r <= wd_r + 5'd1;
            end
            done0_r   <= ok_s & ~owner_r;
            done1_r   <= ok_s & owner_r;
            err0_r    <= fail_s & ~owner_r;
            err1_r    <= fail_s & owner_r;
            busy_r    <= (state_next_s != IDLE);
            p_start_r <= (state_next_s == RUN);
        end
    end

    // The consume strobe must coincide with the cycle rnd_valid is seen.
    assign rnd_ack  = rst & (state_r == WAIT_RND) & rounds_ok_s & rnd_valid;
    assign done0    = done0_r;
    assign done1    = done1_r;
    assign err0     = err0_r;
    assign err1     = err1_r;
    assign res      = res_r;
    assign busy     = busy_r;
    assign p_start  = p_start_r;
    assign p_rounds = rounds_r;
    assign p_in     = shares_r;

endmodule
